// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage and its EX/MEM register.
package ex_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int REG_W   = 5;
    localparam int CONST_W = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_code_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t CTRL_BUBBLE = '{
        valid: FALSE, reg_write: FALSE, mem_to_reg: FALSE,
        mem_read: FALSE, mem_write: FALSE
    };

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; shifts act on operand B, LUI places B in the upper half.
module alu #(
    parameter int W      = 32,
    parameter int LUI_SH = 16
) (
    input  logic [3:0]   code,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   shamt,
    output logic [W-1:0] result
);
    import ex_stage_pkg::*;

    always_comb begin
        result = '0;
        case (code)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_LUI:  result = b << LUI_SH;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, dest select, BEQ resolution and the EX/MEM register.
module ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int CONST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    input  logic [ADDR_W-1:0]  inIncrementedInsn,
    input  logic               inRegDst,
    input  logic               inAluSrc,
    input  logic               inMemToReg,
    input  logic               inRegWrite,
    input  logic               inMemRead,
    input  logic               inMemWrite,
    input  logic               inBranch,
    input  logic [3:0]         inAluCode,
    input  logic [DATA_W-1:0]  inRdDataS,
    input  logic [DATA_W-1:0]  inRdDataT,
    input  logic [REG_W-1:0]   inDcRS,
    input  logic [REG_W-1:0]   inDcRT,
    input  logic [REG_W-1:0]   inDcRD,
    input  logic [ADDR_W-1:0]  inDisp,
    input  logic [CONST_W-1:0] inConstant,
    input  logic               memRegWrite,
    input  logic [REG_W-1:0]   memDstReg,
    input  logic [DATA_W-1:0]  memResult,
    input  logic               wbRegWrite,
    input  logic [REG_W-1:0]   wbDstReg,
    input  logic [DATA_W-1:0]  wbResult,
    input  logic               inStall,
    input  logic               inFlush,
    output logic               outValid,
    output logic               outRegWrite,
    output logic               outMemToReg,
    output logic               outMemRead,
    output logic               outMemWrite,
    output logic [DATA_W-1:0]  outAluResult,
    output logic [DATA_W-1:0]  outStoreData,
    output logic [REG_W-1:0]   outDstReg,
    output logic               outBrTaken,
    output logic [ADDR_W-1:0]  outBrTarget
);
    import ex_stage_pkg::*;

    logic [DATA_W-1:0] fwd_s, fwd_t, sext_const, op_b, alu_b, alu_res;
    logic              br_hit;
    logic [ADDR_W-1:0] br_target;
    exmem_ctrl_t       ctrl_new;

    // MEM is the younger producer, so it wins over WB; r0 is hardwired zero.
    always_comb begin
        fwd_s = inRdDataS;
        if (memRegWrite && memDstReg == inDcRS && inDcRS != '0)
            fwd_s = memResult;
        else if (wbRegWrite && wbDstReg == inDcRS && inDcRS != '0)
            fwd_s = wbResult;

        fwd_t = inRdDataT;
        if (memRegWrite && memDstReg == inDcRT && inDcRT != '0)
            fwd_t = memResult;
        else if (wbRegWrite && wbDstReg == inDcRT && inDcRT != '0)
            fwd_t = wbResult;
    end

    assign sext_const = {{(DATA_W-CONST_W){inConstant[CONST_W-1]}}, inConstant};
    assign op_b       = inAluSrc ? sext_const : fwd_t;
    // LUI always takes the immediate, whatever inAluSrc says.
    assign alu_b      = (inAluCode == ALU_LUI) ? sext_const : op_b;

    alu #(.W(DATA_W), .LUI_SH(DATA_W - CONST_W)) u_alu (
        .code   (inAluCode),
        .a      (fwd_s),
        .b      (alu_b),
        .shamt  (inConstant[10:6]),
        .result (alu_res)
    );

    assign br_hit    = inValid && inBranch && (fwd_s == fwd_t);
    assign br_target = inIncrementedInsn + inDisp;

    always_comb begin
        ctrl_new = CTRL_BUBBLE;
        if (inValid) begin
            ctrl_new.valid      = TRUE;
            ctrl_new.reg_write  = inRegWrite;
            ctrl_new.mem_to_reg = inMemToReg;
            ctrl_new.mem_read   = inMemRead;
            ctrl_new.mem_write  = inMemWrite;
        end
    end

    exmem_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d, store_q, store_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] br_target_q, br_target_d;

    // A registered taken branch squashes the wrong-path instruction behind it.
    always_comb begin
        ctrl_d      = ctrl_q;
        alu_res_d   = alu_res_q;
        store_d     = store_q;
        dst_d       = dst_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        if (inFlush || br_taken_q) begin
            ctrl_d      = CTRL_BUBBLE;
            alu_res_d   = '0;
            store_d     = '0;
            dst_d       = '0;
            br_taken_d  = FALSE;
            br_target_d = '0;
        end else if (!inStall) begin
            ctrl_d      = ctrl_new;
            alu_res_d   = alu_res;
            store_d     = fwd_t;
            dst_d       = inRegDst ? inDcRD : inDcRT;
            br_taken_d  = br_hit;
            br_target_d = br_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q      <= CTRL_BUBBLE;
            alu_res_q   <= '0;
            store_q     <= '0;
            dst_q       <= '0;
            br_taken_q  <= FALSE;
            br_target_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            alu_res_q   <= alu_res_d;
            store_q     <= store_d;
            dst_q       <= dst_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign outValid     = ctrl_q.valid;
    assign outRegWrite  = ctrl_q.reg_write;
    assign outMemToReg  = ctrl_q.mem_to_reg;
    assign outMemRead   = ctrl_q.mem_read;
    assign outMemWrite  = ctrl_q.mem_write;
    assign outAluResult = alu_res_q;
    assign outStoreData = store_q;
    assign outDstReg    = dst_q;
    assign outBrTaken   = br_taken_q;
    assign outBrTarget  = br_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, hand sequences and random vs a reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] incr;
        logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [3:0]  code;
        logic [31:0] ds, dt;
        logic [4:0]  rs, rt, rd;
        logic [31:0] disp;
        logic [15:0] konst;
        logic        mrw;
        logic [4:0]  mdst;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wdst;
        logic [31:0] wres;
        logic        stall, flush;
    } in_t;

    typedef struct packed {
        logic        valid, regwrite, memtoreg, memread, memwrite;
        logic [31:0] alu, store;
        logic [4:0]  dst;
        logic        br;
        logic [31:0] tgt;
    } out_t;

    typedef struct {
        in_t         in;
        logic [31:0] res;
        logic [4:0]  dst;
    } vec_t;

    logic clk, rst;
    in_t  cur;
    out_t expv;
    int   checks, errors;

    logic        outValid, outRegWrite, outMemToReg, outMemRead, outMemWrite, outBrTaken;
    logic [31:0] outAluResult, outStoreData, outBrTarget;
    logic [4:0]  outDstReg;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .inValid(cur.valid), .inIncrementedInsn(cur.incr),
        .inRegDst(cur.regdst), .inAluSrc(cur.alusrc),
        .inMemToReg(cur.memtoreg), .inRegWrite(cur.regwrite),
        .inMemRead(cur.memread), .inMemWrite(cur.memwrite), .inBranch(cur.branch),
        .inAluCode(cur.code), .inRdDataS(cur.ds), .inRdDataT(cur.dt),
        .inDcRS(cur.rs), .inDcRT(cur.rt), .inDcRD(cur.rd),
        .inDisp(cur.disp), .inConstant(cur.konst),
        .memRegWrite(cur.mrw), .memDstReg(cur.mdst), .memResult(cur.mres),
        .wbRegWrite(cur.wrw), .wbDstReg(cur.wdst), .wbResult(cur.wres),
        .inStall(cur.stall), .inFlush(cur.flush),
        .outValid(outValid), .outRegWrite(outRegWrite), .outMemToReg(outMemToReg),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite),
        .outAluResult(outAluResult), .outStoreData(outStoreData),
        .outDstReg(outDstReg), .outBrTaken(outBrTaken), .outBrTarget(outBrTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] operand(input in_t i, input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (i.mrw && i.mdst == r) return i.mres;
        if (i.wrw && i.wdst == r) return i.wres;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] k);
        int sh;
        logic [31:0] r;
        sh = int'(k[10:6]);
        case (code)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA: begin
                r = b >> sh;
                if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            ALU_LUI:  return {k, 16'h0000};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic out_t model_next(input in_t i, input out_t c);
        out_t n;
        logic [31:0] a, t, b;
        n = c;
        if (i.flush || c.br) begin
            n = '0;
        end else if (!i.stall) begin
            a = operand(i, i.rs, i.ds);
            t = operand(i, i.rt, i.dt);
            b = i.alusrc ? {{16{i.konst[15]}}, i.konst} : t;
            n.valid    = i.valid;
            n.regwrite = i.valid & i.regwrite;
            n.memtoreg = i.valid & i.memtoreg;
            n.memread  = i.valid & i.memread;
            n.memwrite = i.valid & i.memwrite;
            n.alu      = ref_alu(i.code, a, b, i.konst);
            n.store    = t;
            n.dst      = i.regdst ? i.rd : i.rt;
            n.br       = i.valid & i.branch & (a == t);
            n.tgt      = i.incr + i.disp;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".valid"},  32'(outValid),     32'(expv.valid));
        check({tag, ".regwr"},  32'(outRegWrite),  32'(expv.regwrite));
        check({tag, ".m2r"},    32'(outMemToReg),  32'(expv.memtoreg));
        check({tag, ".mrd"},    32'(outMemRead),   32'(expv.memread));
        check({tag, ".mwr"},    32'(outMemWrite),  32'(expv.memwrite));
        check({tag, ".alu"},    outAluResult,      expv.alu);
        check({tag, ".store"},  outStoreData,      expv.store);
        check({tag, ".dst"},    32'(outDstReg),    32'(expv.dst));
        check({tag, ".br"},     32'(outBrTaken),   32'(expv.br));
        check({tag, ".tgt"},    outBrTarget,       expv.tgt);
    endtask

    task automatic tick(input string tag);
        out_t nxt;
        nxt = model_next(cur, expv);
        @(posedge clk);
        expv = nxt;
        #1;
        cmp_all(tag);
    endtask

    function automatic in_t base_in();
        in_t v;
        v = '0;
        v.valid = 1'b1; v.regwrite = 1'b1; v.regdst = 1'b1;
        v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        in_t v;
        checks = 0; errors = 0;
        cur = '0; expv = '0;
        rst = 1'b0;
        cur.ds = 32'h1234; cur.valid = 1'b1;

        // Vector table: ALU, forwarding and extension corners
        v = base_in(); v.code = ALU_ADD; v.rs = 5'd3; v.rt = 5'd4; v.ds = 10; v.dt = 20;
        v.mrw = 1; v.mdst = 3; v.mres = 7; v.wrw = 1; v.wdst = 3; v.wres = 9;
        tbl[0] = '{v, 32'd27, 5'd3};
        v = base_in(); v.code = ALU_ADD; v.rs = 0; v.ds = 0; v.mrw = 1; v.mdst = 0; v.mres = 5;
        v.alusrc = 1; v.konst = 16'hFFFF; v.regdst = 0;
        tbl[1] = '{v, 32'hFFFF_FFFF, 5'd2};
        v = base_in(); v.code = ALU_SLT; v.ds = 32'hFFFF_FFFF; v.dt = 1;
        tbl[2] = '{v, 32'd1, 5'd3};
        v.code = ALU_SLTU;
        tbl[3] = '{v, 32'd0, 5'd3};
        v = base_in(); v.code = ALU_SRA; v.dt = 32'h8000_0000; v.konst = 16'h0100;
        tbl[4] = '{v, 32'hF800_0000, 5'd3};
        v = base_in(); v.code = ALU_ADD; v.ds = 32'hFFFF_FFFF; v.dt = 1;
        tbl[5] = '{v, 32'd0, 5'd3};
        v = base_in(); v.code = ALU_SUB; v.rt = 5; v.ds = 32'h300; v.dt = 32'h999;
        v.wrw = 1; v.wdst = 5; v.wres = 32'h100; v.mrw = 1; v.mdst = 6; v.mres = 32'h777;
        tbl[6] = '{v, 32'h200, 5'd3};
        v = base_in(); v.code = ALU_LUI; v.konst = 16'h1234;
        tbl[7] = '{v, 32'h1234_0000, 5'd3};
        v = base_in(); v.code = 4'hF; v.ds = 32'h55; v.dt = 32'h66;
        tbl[8] = '{v, 32'd0, 5'd3};
        v = base_in(); v.code = ALU_NOR;
        tbl[9] = '{v, 32'hFFFF_FFFF, 5'd3};
        v = base_in(); v.code = ALU_SLL; v.dt = 1; v.konst = 16'h07C0;
        tbl[10] = '{v, 32'h8000_0000, 5'd3};
        v = base_in(); v.code = ALU_SRL; v.dt = 32'h8000_0000; v.konst = 16'h0100;
        tbl[11] = '{v, 32'h0800_0000, 5'd3};

        #2;
        cmp_all("reset0");
        #6 rst = 1'b1;

        foreach (tbl[k]) begin
            cur = tbl[k].in;
            tick("tbl");
            check("tbl_res", outAluResult, tbl[k].res);
            check("tbl_dst", 32'(outDstReg), 32'(tbl[k].dst));
        end

        // Stall freezes outputs, then stall+flush latches a bubble
        cur = base_in(); cur.code = ALU_ADD; cur.ds = 10; cur.dt = 20;
        tick("pre_stall");
        check("pre_stall_res", outAluResult, 32'd30);
        cur.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cur.ds = cur.ds + 5; cur.code = ALU_SUB; cur.valid = s[0];
            tick("stall");
            check("stall_hold", outAluResult, 32'd30);
            check("stall_valid", 32'(outValid), 32'd1);
        end
        cur.flush = 1'b1;
        tick("stall_flush");
        check("flush_valid", 32'(outValid), 32'd0);
        check("flush_res", outAluResult, 32'd0);

        // BEQ arriving during a stall is held until release, then squashes its successor
        cur = base_in(); cur.branch = 1; cur.code = ALU_SUB; cur.ds = 32'h55; cur.dt = 32'h55;
        cur.incr = 32'h100; cur.disp = 32'h20; cur.stall = 1'b1;
        tick("br_stall");
        check("br_stall_taken", 32'(outBrTaken), 32'd0);
        cur.stall = 1'b0;
        tick("br");
        check("br_taken", 32'(outBrTaken), 32'd1);
        check("br_target", outBrTarget, 32'h120);
        tick("br_shadow");
        check("shadow_valid", 32'(outValid), 32'd0);
        check("shadow_taken", 32'(outBrTaken), 32'd0);
        cur.incr = 32'hFFFF_FFF0;
        tick("br_wrap");
        check("wrap_target", outBrTarget, 32'h10);

        // Asynchronous reset mid-cycle with live inputs
        #3 rst = 1'b0;
        #1 expv = '0;
        cmp_all("async_rst");
        @(posedge clk); #1;
        cmp_all("rst_hold");
        #2 rst = 1'b1;
        #1 cmp_all("rst_release");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cur.valid    = ($urandom_range(0, 4) != 0);
            cur.incr     = $urandom; cur.disp = $urandom;
            cur.regdst   = 1'($urandom); cur.alusrc = 1'($urandom);
            cur.memtoreg = 1'($urandom); cur.regwrite = 1'($urandom);
            cur.memread  = 1'($urandom); cur.memwrite = 1'($urandom);
            cur.branch   = ($urandom_range(0, 2) == 0);
            cur.code     = 4'($urandom);
            cur.ds       = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            cur.dt       = ($urandom_range(0, 2) == 0) ? cur.ds : $urandom;
            cur.rs       = 5'($urandom_range(0, 3)); cur.rt = 5'($urandom_range(0, 3));
            cur.rd       = 5'($urandom);
            cur.konst    = 16'($urandom);
            cur.mrw      = 1'($urandom); cur.mdst = 5'($urandom_range(0, 3)); cur.mres = $urandom;
            cur.wrw      = 1'($urandom); cur.wdst = 5'($urandom_range(0, 3)); cur.wres = $urandom;
            cur.stall    = ($urandom_range(0, 4) == 0);
            cur.flush    = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register; consumes its control, operand, register-number, displacement and constant outputs.
- Performs operand forwarding from the MEM and WB stages, the ALU operation, destination-register selection and branch resolution.
- Latches all results into the EX/MEM register; a registered taken-branch redirects fetch and squashes wrong-path work.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 32, instruction-address width
REG_W, 5, register-number width
CONST_W, 16, immediate width; sign-extended to DATA_W

Ports:
clk  in  1  clock
rst  in  1  reset
inValid  in  1  ID/EX holds a real instruction
inIncrementedInsn  in  ADDR_W  PC+4 of instruction
inRegDst  in  1  1: dest = RD, 0: dest = RT
inAluSrc  in  1  1: operand B = sign-extended constant
inMemToReg, inRegWrite, inMemRead, inMemWrite, inBranch  in  1 each  control
inAluCode  in  4  ALU operation (package enum)
inRdDataS, inRdDataT  in  DATA_W  register-file read data
inDcRS, inDcRT, inDcRD  in  REG_W  source/dest register numbers
inDisp  in  ADDR_W  branch byte displacement (already shifted by decoder)
inConstant  in  CONST_W  immediate
memRegWrite  in  1  MEM-stage instruction writes a register
memDstReg  in  REG_W  MEM-stage dest
memResult  in  DATA_W  MEM-stage ALU result
wbRegWrite  in  1  WB-stage write enable
wbDstReg  in  REG_W  WB dest
wbResult  in  DATA_W  WB write data
inStall  in  1  hold the EX/MEM register
inFlush  in  1  external squash of the instruction in EX
outValid, outRegWrite, outMemToReg, outMemRead, outMemWrite  out  1 each  EX/MEM control
outAluResult  out  DATA_W  ALU result / memory address
outStoreData  out  DATA_W  forwarded RT value for stores
outDstReg  out  REG_W  selected dest register
outBrTaken  out  1  registered branch taken
outBrTarget  out  ADDR_W  registered branch target

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. Asynchronous assertion clears every output to 0; clearing is immediate, including mid-stall or mid-branch.
- Latency: 1 cycle; EX/MEM outputs reflect ID/EX inputs sampled at the previous rising edge.
- Forwarding for operand A (RS) and operand B/store data (RT), evaluated independently:
  - If memRegWrite && memDstReg == src && src != 0, use memResult.
  - Else if wbRegWrite && wbDstReg == src && src != 0, use wbResult.
  - Else use the register-file data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand B: sign-extended inConstant if inAluSrc, else forwarded RT.
- ALU codes: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA, LUI.
  - Shifts use inConstant[10:6] as shift amount on operand B.
  - LUI result = {inConstant, 16'b0}.
  - Add/sub wrap modulo 2^DATA_W; no overflow trap.
  - Undefined codes give result 0.
- Dest register: inDcRD if inRegDst, else inDcRT.
- Branch (BEQ semantics):
  - taken = inValid && inBranch && (A == B after forwarding).
  - target = inIncrementedInsn + inDisp, modulo 2^ADDR_W.
- Latch priority each edge, highest first:
  1. Squash: if inFlush || outBrTaken, latch a bubble. All control, outValid and outBrTaken go to 0; data fields don't-care (implemented as 0). outBrTaken is therefore never high for 2 consecutive cycles.
  2. inStall: hold every output unchanged, including outBrTaken.
  3. Normal: latch new results. If !inValid, control and outBrTaken are forced to 0.
- Simultaneous inStall and inFlush: flush wins.
- Simultaneous branch-taken and inStall: redirect is held until the stall releases.

Decomposition:
- Shared package holds the ALU code enum, DATA_W/ADDR_W/REG_W/CONST_W constants, TRUE/FALSE, and a bubble constant for the EX/MEM control bundle.
- One sub-module, alu, is combinational: code, A, B and shamt in; result out.
- Forwarding muxes, branch compare and the EX/MEM register remain in ex_stage.

Test Plan:
- Reset with inputs nonzero: assert rst=0 mid-cycle -> all outputs 0 immediately, and they stay 0 until the first edge after release.
- ADD with RS=3 (10), RT=4 (20), memRegWrite=1, memDstReg=3, memResult=7, wbDstReg=3, wbResult=9 -> outAluResult=27 next cycle (MEM beats WB).
- Forward to register 0: inDcRS=0, memDstReg=0, memResult=5, inRdDataS=0, ADDI constant 0xFFFF -> outAluResult=0xFFFFFFFF (no forward, sign-extension).
- BEQ A=B=0x55, inIncrementedInsn=0x100, inDisp=0x20 -> outBrTaken=1, outBrTarget=0x120. The following cycle outValid=0 and outBrTaken=0 even though inValid=1.
- inStall=1 for 3 cycles with changing inputs -> outputs frozen. Then inStall=1 with inFlush=1 -> bubble latched.
- SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0; SRA 0x80000000 by 4 -> 0xF8000000; ADD 0xFFFFFFFF+1 -> 0.
